tube_chan_ctrl: RTL and testbench
=================================

Name: tube_chan_ctrl

Overview:
- Flag and sequencing controller for the host-to-parasite Tube channel latches.
- Synchronises asynchronous host write strobes into the parasite clock domain and captures host data into per-channel FIFOs (depth 1 or 2).
- Sequences the data-available / not-full flags, which replace gate-level set/reset flag flops, as registered state with defined priority.
- Generates the parasite interrupt and handles overflow.

Parameters:
- NCH, 4, number of channels (1..4).
- DEPTH, 1, entries per channel FIFO (1 or 2).
- SYNC_STAGES, 2, synchroniser flops on h_wr_stb (>=2).
- DW, 8, data width.

Ports:
- clk  in  1  parasite clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- h_wr_stb  in  1  asynchronous host write strobe, active high; h_addr/h_din are stable while it is high.
- h_addr  in  2  host channel select (quasi-static while h_wr_stb is high).
- h_din  in  DW  host write data.
- p_rd  in  1  parasite read pulse, synchronous, one cycle per read.
- p_addr  in  2  parasite channel select.
- p_dout  out  DW  read data, registered.
- data_avail  out  NCH  per-channel FIFO non-empty.
- not_full  out  NCH  per-channel FIFO has space (host status bits).
- irq_en  in  NCH  per-channel interrupt enable.
- p_irq  out  1  registered interrupt: OR(data_avail & irq_en).
- ovf  out  NCH  sticky overflow flag per channel.
- ovf_clr  in  NCH  clear-overflow pulses.

Behaviour:
- **Reset values:** p_dout=0, data_avail=0, not_full=all 1, ovf=0, p_irq=0, all FIFO counts 0, synchroniser flops 0, edge-detect history 0. Reset mid-transfer discards FIFO contents. A strobe still high when rst deasserts does not produce a write (history starts at 0, but the synchroniser must see a 0 first, so an edge is only generated after a low-to-high transition).
- **Host write path:**
  - h_wr_stb passes through SYNC_STAGES flops plus one history flop; a write event (hw) is the one-cycle pulse on a synchronised 0->1 transition.
  - h_addr and h_din are captured into staging registers on the same cycle as hw.
  - The write commits to the FIFO the following cycle. Latency from the strobe edge to data_avail set is SYNC_STAGES+2 clk cycles.
  - Addresses >= NCH are ignored (no flag change).
- **Parasite read path:**
  - p_rd with p_addr<NCH and count>0: p_dout takes the head entry on the next edge; the FIFO pops.
  - Read of an empty channel: p_dout takes the last value read from that channel; no flag change.
  - Out-of-range p_addr: p_dout=0.
- **Per-channel count arithmetic** (2-bit counter, 0..DEPTH):
  - Write only, count<DEPTH: push, count+1.
  - Write only, count==DEPTH: data dropped, ovf set, count unchanged.
  - Read only, count>0: pop, count-1.
  - Simultaneous write and read on the same channel, 0<count<=DEPTH: both occur, count unchanged. At count==DEPTH the write is accepted, because the pop frees the slot.
  - Simultaneous write and read on the same channel, count==0: the write is accepted and the read is treated as an empty read. New data is not forwarded in the same cycle.
- **Flag derivation:** data_avail=(count!=0) and not_full=(count!=DEPTH), both registered, i.e. updated on the same edge as count.
- **FIFO storage (DEPTH=2):** two-entry register with head index; pop toggles the head, and the write slot is head^count. With DEPTH=1, a single register.
- **ovf:** set on a dropped write; cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- **p_irq:** registered one cycle after data_avail/irq_en change.

Decomposition:
- Shared package tube_pkg holds:
  - DW and max-NCH constants;
  - channel-address typedef;
  - counter typedef;
  - reset constants for the flag vectors.
- One sub-module, tube_chan_fifo (one per channel; count, storage, ovf), instantiated NCH times under a generate.
- The synchroniser/edge detector stays inline in tube_chan_ctrl.

Test Plan:
1. **Reset/idle:** rst 3 cycles, h_wr_stb=1 held through reset release -> no write; data_avail=0, not_full=4'b1111, p_irq=0. Then take h_wr_stb low, raise it with h_addr=1, h_din=8'hA5 -> data_avail=4'b0010 exactly 4 cycles after the strobe edge (SYNC_STAGES=2).
2. **Read and interrupt:** irq_en=4'b0010 with channel 1 holding 8'hA5 -> p_irq=1 one cycle after data_avail. p_rd with p_addr=1 -> next cycle p_dout=8'hA5, data_avail=0; the cycle after, p_irq=0.
3. **Overflow, DEPTH=2:** host writes 8'h11, 8'h22, 8'h33 to channel 0 -> not_full[0]=0 after the second write; ovf[0]=1 after the third. Reads return 8'h11 then 8'h22, then an empty read returns 8'h22 again. Pulse ovf_clr[0] -> ovf[0]=0.
4. **Simultaneous at full, DEPTH=2:** channel 2 full with 8'h01, 8'h02; p_rd on channel 2 in the same cycle as the host commit of 8'h03 -> p_dout=8'h01, count stays 2, ovf=0. Subsequent reads return 8'h02 then 8'h03.
5. **Simultaneous at empty:** channel 3 empty; p_rd coincides with the commit of 8'h5A -> p_dout unchanged (previous channel-3 value), data_avail[3]=1. Next read returns 8'h5A.
6. **Reset mid-operation:** channel 0 holding 2 entries with ovf[0]=1; assert rst for one cycle -> all flags return to reset values. Then p_rd on channel 0 -> data_avail stays 0 and p_dout=0.

Source files
------------

// File: rtl/tube_pkg.sv
// Tube channel shared types and constants.
// Imported by the channel controller and its per-channel FIFO.
package tube_pkg;

  localparam int TUBE_DW = 8;
  localparam int MAX_NCH = 4;

  typedef logic [1:0] chan_t;
  typedef logic [1:0] cnt_t;

  localparam logic [MAX_NCH-1:0] AVAIL_RST = '0;
  localparam logic [MAX_NCH-1:0] NFULL_RST = '1;
  localparam logic [MAX_NCH-1:0] OVF_RST   = '0;

endpackage

// File: rtl/tube_chan_fifo.sv
// One host-to-parasite channel: 1- or 2-entry FIFO,
// registered flags, last-read hold and sticky overflow.
module tube_chan_fifo
  import tube_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = TUBE_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  input  logic          ovf_clr,
  output logic [DW-1:0] rdata,
  output logic          data_avail,
  output logic          not_full,
  output logic          ovf
);

  localparam cnt_t FULL = cnt_t'(DEPTH);

  cnt_t          count;
  cnt_t          count_nxt;
  logic          push;
  logic          pop;
  logic [DW-1:0] head_q;
  logic [DW-1:0] last_q;

  // A pop at full frees the slot the write lands in.
  always_comb begin
    pop       = rd && (count != '0);
    push      = wr && ((count != FULL) || pop);
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      data_avail <= AVAIL_RST[0];
      not_full   <= NFULL_RST[0];
      ovf        <= OVF_RST[0];
      last_q     <= '0;
    end else begin
      count      <= count_nxt;
      data_avail <= (count_nxt != '0);
      not_full   <= (count_nxt != FULL);
      if (wr && !push)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      if (pop)
        last_q <= head_q;
    end
  end

  assign rdata = (count != '0) ? head_q : last_q;

  if (DEPTH == 2) begin : g_two
    logic [DW-1:0] mem0;
    logic [DW-1:0] mem1;
    logic          head;
    logic          slot;

    assign slot = head ^ count[0];

    always_ff @(posedge clk) begin
      if (rst)
        head <= 1'b0;
      else if (pop)
        head <= ~head;
    end

    always_ff @(posedge clk) begin
      if (push && slot)
        mem1 <= wdata;
      if (push && !slot)
        mem0 <= wdata;
    end

    assign head_q = head ? mem1 : mem0;
  end else begin : g_one
    logic [DW-1:0] mem0;

    always_ff @(posedge clk) begin
      if (push)
        mem0 <= wdata;
    end

    assign head_q = mem0;
  end

endmodule

// File: rtl/tube_chan_ctrl.sv
// Tube host-to-parasite channel controller: strobe sync,
// write staging, per-channel FIFOs, read port and interrupt.
module tube_chan_ctrl
  import tube_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DEPTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int DW          = TUBE_DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           h_wr_stb,
  input  logic [1:0]     h_addr,
  input  logic [DW-1:0]  h_din,
  input  logic           p_rd,
  input  logic [1:0]     p_addr,
  output logic [DW-1:0]  p_dout,
  output logic [NCH-1:0] data_avail,
  output logic [NCH-1:0] not_full,
  input  logic [NCH-1:0] irq_en,
  output logic           p_irq,
  output logic [NCH-1:0] ovf,
  input  logic [NCH-1:0] ovf_clr
);

  localparam int SM = SYNC_STAGES - 1;

  logic [SM:0]   sync_q;
  logic [SM:0]   vld_q;
  logic          sync_out;
  logic          hist_q;
  logic          armed_q;
  logic          hw;

  logic          wr_q;
  chan_t         wa_q;
  logic [DW-1:0] wd_q;

  logic [DW-1:0] rdata [NCH];
  logic [DW-1:0] rsel;

  assign sync_out = sync_q[SM];

  // Edges are armed only once a real post-reset low is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      vld_q   <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SM-1:0], h_wr_stb};
      vld_q   <= {vld_q[SM-1:0], 1'b1};
      hist_q  <= sync_out;
      armed_q <= armed_q | (vld_q[SM] & ~sync_out);
    end
  end

  assign hw = armed_q & sync_out & ~hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      wr_q <= hw;
      if (hw) begin
        wa_q <= h_addr;
        wd_q <= h_din;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tube_chan_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr         (wr_q && (wa_q == chan_t'(i))),
      .wdata      (wd_q),
      .rd         (p_rd && (p_addr == chan_t'(i))),
      .ovf_clr    (ovf_clr[i]),
      .rdata      (rdata[i]),
      .data_avail (data_avail[i]),
      .not_full   (not_full[i]),
      .ovf        (ovf[i])
    );
  end

  always_comb begin
    rsel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (p_addr == chan_t'(i))
        rsel = rdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_dout <= '0;
      p_irq  <= 1'b0;
    end else begin
      if (p_rd)
        p_dout <= rsel;
      p_irq <= |(data_avail & irq_en);
    end
  end

endmodule

// File: tb/tb_tube_chan_ctrl.sv
// Directed bench for tube_chan_ctrl with 4 channels,
// 2-entry FIFOs and a 2-stage strobe synchroniser.
module tb_tube_chan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_wr_stb;
  logic [1:0] h_addr;
  logic [7:0] h_din;
  logic       p_rd;
  logic [1:0] p_addr;
  logic [7:0] p_dout;
  logic [3:0] data_avail;
  logic [3:0] not_full;
  logic [3:0] irq_en;
  logic       p_irq;
  logic [3:0] ovf;
  logic [3:0] ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  tube_chan_ctrl #(
    .NCH         (4),
    .DEPTH       (2),
    .SYNC_STAGES (2),
    .DW          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .h_wr_stb   (h_wr_stb),
    .h_addr     (h_addr),
    .h_din      (h_din),
    .p_rd       (p_rd),
    .p_addr     (p_addr),
    .p_dout     (p_dout),
    .data_avail (data_avail),
    .not_full   (not_full),
    .irq_en     (irq_en),
    .p_irq      (p_irq),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe edge, commit lands on the 4th edge, then settle low.
  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    h_addr   = a;
    h_din    = d;
    h_wr_stb = 1'b1;
    repeat (3) tick();
    h_wr_stb = 1'b0;
    repeat (3) tick();
  endtask

  task automatic host_wr_rd(input logic [1:0] a, input logic [7:0] d,
                            input logic [1:0] ra);
    h_addr   = a;
    h_din    = d;
    h_wr_stb = 1'b1;
    repeat (3) tick();
    h_wr_stb = 1'b0;
    p_rd     = 1'b1;
    p_addr   = ra;
    tick();
    p_rd     = 1'b0;
  endtask

  task automatic par_rd(input logic [1:0] a);
    p_rd   = 1'b1;
    p_addr = a;
    tick();
    p_rd   = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    h_wr_stb = 1'b1;
    h_addr   = 2'd1;
    h_din    = 8'hA5;
    p_rd     = 1'b0;
    p_addr   = 2'd0;
    irq_en   = 4'b0000;
    ovf_clr  = 4'b0000;

    // 1: reset with strobe held high
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    check("rst_avail", data_avail, 4'b0000);
    check("rst_nfull", not_full, 4'b1111);
    check("rst_irq", p_irq, 1'b0);
    check("rst_dout", p_dout, 8'h00);
    check("rst_ovf", ovf, 4'b0000);
    h_wr_stb = 1'b0;
    repeat (4) tick();
    h_addr   = 2'd1;
    h_din    = 8'hA5;
    h_wr_stb = 1'b1;
    repeat (3) tick();
    check("lat3_avail", data_avail, 4'b0000);
    tick();
    check("lat4_avail", data_avail, 4'b0010);
    h_wr_stb = 1'b0;
    repeat (3) tick();

    // 2: read and interrupt
    check("irq_off", p_irq, 1'b0);
    irq_en = 4'b0010;
    tick();
    check("irq_on", p_irq, 1'b1);
    par_rd(2'd1);
    check("rd1_dout", p_dout, 8'hA5);
    check("rd1_avail", data_avail, 4'b0000);
    check("rd1_irq_hold", p_irq, 1'b1);
    tick();
    check("rd1_irq_drop", p_irq, 1'b0);
    irq_en = 4'b0000;

    // 3: overflow on channel 0
    host_wr(2'd0, 8'h11);
    check("c0_w1_avail", data_avail, 4'b0001);
    check("c0_w1_nfull", not_full, 4'b1111);
    host_wr(2'd0, 8'h22);
    check("c0_w2_nfull", not_full, 4'b1110);
    check("c0_w2_ovf", ovf, 4'b0000);
    host_wr(2'd0, 8'h33);
    check("c0_w3_ovf", ovf, 4'b0001);
    check("c0_w3_nfull", not_full, 4'b1110);
    par_rd(2'd0);
    check("c0_rd1", p_dout, 8'h11);
    check("c0_rd1_nfull", not_full, 4'b1111);
    par_rd(2'd0);
    check("c0_rd2", p_dout, 8'h22);
    check("c0_rd2_avail", data_avail, 4'b0000);
    par_rd(2'd0);
    check("c0_rd_empty", p_dout, 8'h22);
    check("c0_empty_avail", data_avail, 4'b0000);
    ovf_clr = 4'b0001;
    tick();
    ovf_clr = 4'b0000;
    check("c0_ovf_clr", ovf, 4'b0000);

    // 4: simultaneous read and write at full, channel 2
    host_wr(2'd2, 8'h01);
    host_wr(2'd2, 8'h02);
    check("c2_full_nfull", not_full, 4'b1011);
    host_wr_rd(2'd2, 8'h03, 2'd2);
    check("c2_sim_dout", p_dout, 8'h01);
    check("c2_sim_nfull", not_full, 4'b1011);
    check("c2_sim_avail", data_avail, 4'b0100);
    check("c2_sim_ovf", ovf, 4'b0000);
    repeat (2) tick();
    par_rd(2'd2);
    check("c2_rd2", p_dout, 8'h02);
    par_rd(2'd2);
    check("c2_rd3", p_dout, 8'h03);
    check("c2_rd3_avail", data_avail, 4'b0000);

    // 5: simultaneous read and write at empty, channel 3
    host_wr(2'd3, 8'h77);
    par_rd(2'd3);
    check("c3_prime", p_dout, 8'h77);
    host_wr_rd(2'd3, 8'h5A, 2'd3);
    check("c3_sim_dout", p_dout, 8'h77);
    check("c3_sim_avail", data_avail, 4'b1000);
    repeat (2) tick();
    par_rd(2'd3);
    check("c3_rd", p_dout, 8'h5A);
    check("c3_rd_avail", data_avail, 4'b0000);

    // 6: reset mid-operation
    host_wr(2'd0, 8'hAA);
    host_wr(2'd0, 8'hBB);
    host_wr(2'd0, 8'hCC);
    check("c0_pre_ovf", ovf, 4'b0001);
    check("c0_pre_avail", data_avail, 4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_avail", data_avail, 4'b0000);
    check("mid_rst_nfull", not_full, 4'b1111);
    check("mid_rst_ovf", ovf, 4'b0000);
    check("mid_rst_dout", p_dout, 8'h00);
    par_rd(2'd0);
    check("post_rst_avail", data_avail, 4'b0000);
    check("post_rst_dout", p_dout, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
